fifo_wr_arbiter: RTL and testbench

// - Shares the write port of one synchronous FIFO among NUM_REQ producers.
// - Round-robin arbitration with optional burst lock: a winner keeps the port for up to MAX_BURST consecutive beats.
// - One registered output stage drives FIFO wr_en/wr_data; the FIFO's wr_valid (accepted-write) signal drains it.
// - Sits between producer blocks and the FIFO write side; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Modulo-n increment without relying on power-of-2 wrap.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping N-1 -> 0.
// Purely combinational, no backpressure of its own.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write-port arbiter with burst lock; a beat accepted at t is on fifo_wr_* at t+1.
// Backpressure: req_ready drops for everyone while the output register is full and the FIFO does not take it.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] fifo_wr_src,
    input  logic                       fifo_wr_valid,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_src;

    logic               accept;
    logic               locked;
    logic [IW-1:0]      owner_inc;
    logic [IW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               hs;

    assign accept    = !out_valid || fifo_wr_valid;
    assign locked    = (state == ARB_LOCK) && req_valid[owner];
    assign owner_inc = IW'(next_idx(int'(owner), NUM_REQ));
    // A dropped owner hands over in the same cycle, searching from the slot after it.
    assign pick_ptr  = (state == ARB_LOCK) ? owner_inc : rr_ptr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (pick_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign grant     = locked ? owner_oh : pick_gnt;
    assign grant_idx = locked ? owner : pick_idx;
    assign req_ready = (reset || !accept) ? '0 : grant;
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        if (accept) begin
            if (locked) begin
                if (beat_cnt == CW'(MAX_BURST - 1)) begin
                    rr_ptr_nxt = owner_inc;
                    state_nxt  = ARB_IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end else begin
                if (state == ARB_LOCK) begin
                    rr_ptr_nxt = owner_inc;
                    state_nxt  = ARB_IDLE;
                end
                if (pick_any) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_nxt = IW'(next_idx(int'(pick_idx), NUM_REQ));
                    end else begin
                        owner_nxt    = pick_idx;
                        beat_cnt_nxt = CW'(1);
                        state_nxt    = ARB_LOCK;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (hs) begin
            out_valid <= 1'b1;
            out_data  <= req_data[grant_idx*WIDTH +: WIDTH];
            out_src   <= grant_idx;
        end else if (fifo_wr_valid) begin
            out_valid <= 1'b0;
        end
    end

    assign fifo_wr_en   = out_valid;
    assign fifo_wr_data = out_data;
    assign fifo_wr_src  = out_src;
    assign busy         = out_valid || (state == ARB_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter in three configurations (4/burst1, 4/burst4, 3/burst1).
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic clock;
    logic reset;

    logic [3:0]   v1, r1;
    logic [127:0] d1;
    logic         en1, fwv1, busy1;
    logic [31:0]  dat1;
    logic [1:0]   src1;

    logic [3:0]   v4, r4;
    logic [127:0] d4;
    logic         en4, fwv4, busy4;
    logic [31:0]  dat4;
    logic [1:0]   src4;

    logic [2:0]   v3, r3;
    logic [95:0]  d3;
    logic         en3, fwv3, busy3;
    logic [31:0]  dat3;
    logic [1:0]   src3;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(1)) u_b1 (
        .clock(clock), .reset(reset), .req_valid(v1), .req_data(d1), .req_ready(r1),
        .fifo_wr_en(en1), .fifo_wr_data(dat1), .fifo_wr_src(src1),
        .fifo_wr_valid(fwv1), .busy(busy1)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(4)) u_b4 (
        .clock(clock), .reset(reset), .req_valid(v4), .req_data(d4), .req_ready(r4),
        .fifo_wr_en(en4), .fifo_wr_data(dat4), .fifo_wr_src(src4),
        .fifo_wr_valid(fwv4), .busy(busy4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(32), .MAX_BURST(1)) u_n3 (
        .clock(clock), .reset(reset), .req_valid(v3), .req_data(d3), .req_ready(r3),
        .fifo_wr_en(en3), .fifo_wr_data(dat3), .fifo_wr_src(src3),
        .fifo_wr_valid(fwv3), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        v1 = 4'b0101; v4 = '0; v3 = '0;
        fwv1 = 1'b1; fwv4 = 1'b1; fwv3 = 1'b1;
        d1 = {32'hB103, 32'hB102, 32'hB101, 32'hB100};
        d4 = {32'hC403, 32'hC402, 32'hC401, 32'hC400};
        d3 = {32'hD302, 32'hD301, 32'hD300};
        step();
        step();

        // Reset state, with requests already pending.
        check("rst_ready", 32'(r1), 0);
        check("rst_en",    32'(en1), 0);
        check("rst_busy",  32'(busy1), 0);
        check("rst_src",   32'(src1), 0);
        check("rst_data",  dat1, 0);
        check("rst_state", 32'(u_b4.state), 32'(ARB_IDLE));

        // Pure round-robin: 0,2,0,2.
        reset = 1'b0;
        #1;
        check("rr_ready0", 32'(r1), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_en",    32'(en1), 1);
            check("rr_src",   32'(src1), (k % 2 == 1) ? 2 : 0);
            check("rr_data",  dat1, (k % 2 == 1) ? 32'hB102 : 32'hB100);
            check("rr_ready", 32'(r1), (k % 2 == 1) ? 32'h1 : 32'h4);
        end
        v1 = '0;

        // Burst of 4 per requester, back to back.
        v4 = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            step();
            check("burst_en",  32'(en4), 1);
            check("burst_src", 32'(src4), k / 4);
        end
        v4 = '0;
        step();
        check("burst_drain_en",   32'(en4), 0);
        check("burst_drain_busy", 32'(busy4), 0);

        // Owner drops mid-burst; req 3 takes over in the same cycle.
        v4 = 4'b1010;
        #1;
        check("drop_ready0", 32'(r4), 32'h2);
        step();
        check("drop_src_a", 32'(src4), 1);
        step();
        check("drop_src_b", 32'(src4), 1);
        v4 = 4'b1000;
        #1;
        check("drop_handover", 32'(r4), 32'h8);
        step();
        check("drop_src_c",  32'(src4), 3);
        check("drop_data_c", dat4, 32'hC403);
        check("drop_rr_ptr", 32'(u_b4.rr_ptr), 2);
        v4 = '0;
        #1;
        check("drop_idle_ready", 32'(r4), 0);
        step();
        check("drop_end_en",   32'(en4), 0);
        check("drop_end_busy", 32'(busy4), 0);

        // FIFO full for 5 cycles with a beat in the output register.
        d4[31:0] = 32'h1000;
        v4 = 4'b0001;
        step();
        check("full_first", dat4, 32'h1000);
        fwv4 = 1'b0;
        d4[31:0] = 32'h1001;
        #1;
        check("full_ready", 32'(r4), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("full_en",    32'(en4), 1);
            check("full_data",  dat4, 32'h1000);
            check("full_ready", 32'(r4), 0);
        end
        fwv4 = 1'b1;
        #1;
        check("full_release_ready", 32'(r4), 32'h1);
        step();
        check("full_next_a", dat4, 32'h1001);
        d4[31:0] = 32'h1002;
        step();
        check("full_next_b", dat4, 32'h1002);
        check("full_next_en", 32'(en4), 1);
        v4 = '0;
        step();
        check("full_drain_en",   32'(en4), 0);
        check("full_drain_busy", 32'(busy4), 0);

        // Reset in the middle of a burst.
        d4[31:0] = 32'hC400;
        v4 = 4'b1111;
        step();
        step();
        check("mid_en", 32'(en4), 1);
        reset = 1'b1;
        step();
        check("mid_rst_en",    32'(en4), 0);
        check("mid_rst_busy",  32'(busy4), 0);
        check("mid_rst_state", 32'(u_b4.state), 32'(ARB_IDLE));
        check("mid_rst_ready", 32'(r4), 0);
        reset = 1'b0;
        #1;
        check("mid_restart", 32'(r4), 32'h1);
        v4 = '0;
        step();

        // Three requesters, only the last one active: pointer wraps 2 -> 0.
        v3 = 3'b100;
        #1;
        check("n3_ready0", 32'(r3), 32'h4);
        for (int k = 0; k < 3; k++) begin
            step();
            check("n3_en",     32'(en3), 1);
            check("n3_src",    32'(src3), 2);
            check("n3_data",   dat3, 32'hD302);
            check("n3_rr_ptr", 32'(u_n3.rr_ptr), 0);
            check("n3_ready",  32'(r3), 32'h4);
        end
        v3 = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
